// File: rtl/axis_bram_pkg.sv
//------------------------------------------------------------------------------
// axis_bram_pkg
//
// Shared definitions for the AXI4-Stream to ping-pong BRAM writer:
//   - wr_state_e : write FSM states (idle bubble, accepting, dropping overflow)
//   - NUM_BANKS  : number of BRAM banks in the ping-pong region
//   - clog2()    : constant ceil(log2()) used to size offsets, lengths and
//                  addresses from the bank depth parameter
//------------------------------------------------------------------------------
package axis_bram_pkg;

   // Write FSM states.
   //   ST_IDLE   : TREADY low; waits for the target bank to be free.
   //   ST_ACCEPT : TREADY high; accepted beats are written to BRAM.
   //   ST_DROP   : TREADY high; bank is full, beats are consumed and
   //               discarded until TLAST.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_DROP   = 2'd2
   } wr_state_e;

   localparam int NUM_BANKS = 2;

   // Ceiling log2 for elaboration-time sizing. clog2(1) = 0, clog2(8) = 3,
   // clog2(9) = 4.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : axis_bram_pkg

// File: rtl/axis_bram_bank_ctrl.sv
//------------------------------------------------------------------------------
// axis_bram_bank_ctrl
//
// Owns the ping-pong bank bookkeeping for axis_bram_pingpong_writer:
// per-bank full flags, the bank currently being written, and arbitration
// between frame commits (set a flag) and consumer releases (clear a flag).
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   commit_i       in   a frame is committed to the current write bank
//   release_i      in   per-bank release pulses from the consumer
//   wr_bank_o      out  bank the writer is (or will be) filling
//   bank_full_o    out  per-bank full flags
//   wr_bank_full_o out  full flag of the current write bank
//------------------------------------------------------------------------------
module axis_bram_bank_ctrl
   import axis_bram_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 commit_i,
   input  logic [NUM_BANKS-1:0] release_i,
   output logic                 wr_bank_o,
   output logic [NUM_BANKS-1:0] bank_full_o,
   output logic                 wr_bank_full_o
);

   logic [NUM_BANKS-1:0] full_q;
   logic [NUM_BANKS-1:0] full_d;
   logic                 wr_bank_q;
   logic                 wr_bank_d;

   // Releases are applied first and the commit afterwards, so a commit
   // always wins on its own bank. A release aimed at the bank being written
   // only ever hits a flag that is already clear, so it has no effect, and a
   // release of the other bank in the same cycle as a commit is honoured.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (release_i[i]) begin
            full_d[i] = 1'b0;
         end
      end
      if (commit_i) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
      end
   end

   assign wr_bank_o      = wr_bank_q;
   assign bank_full_o    = full_q;
   assign wr_bank_full_o = full_q[wr_bank_q];

endmodule : axis_bram_bank_ctrl

// File: rtl/axis_bram_pingpong_writer.sv
//------------------------------------------------------------------------------
// axis_bram_pingpong_writer
//
// AXI4-Stream slave that stores each incoming frame into one half of a
// two-bank BRAM region, alternating banks 0,1,0,... Frames longer than a
// bank are truncated (excess beats are consumed but not written). Each
// committed frame is reported with a one-cycle FRAME_DONE pulse and the bank
// is held full, with backpressure, until the consumer releases it.
//
// Build option:
//   AXIS_BRAM_TSTRB_EN  defined   : BRAM_WE follows TSTRB of the written beat
//                       undefined : TSTRB ignored, BRAM_WE all ones on writes
//
// Ports:
//   S_AXIS_ACLK    in   clock
//   S_AXIS_ARESET  in   asynchronous active-high reset
//   S_AXIS_TVALID  in   source beat valid
//   S_AXIS_TREADY  out  sink ready (registered state only, never from TVALID)
//   S_AXIS_TDATA   in   beat data
//   S_AXIS_TSTRB   in   byte qualifier
//   S_AXIS_TLAST   in   last beat of frame
//   BRAM_EN        out  BRAM port A enable (registered)
//   BRAM_WE        out  byte write enables (registered)
//   BRAM_ADDR      out  word address {bank, offset} (registered)
//   BRAM_DIN       out  write data (registered)
//   FRAME_DONE     out  one-cycle commit pulse
//   FRAME_BANK     out  bank of committed frame
//   FRAME_LEN      out  stored beats, 1..C_BANK_DEPTH
//   FRAME_TRUNC    out  committed frame was truncated
//   BANK_FULL      out  per-bank full flags
//   BANK_RELEASE   in   per-bank release pulses
//
// Handshake: a beat transfers on a rising edge where TVALID and TREADY are
// both high. TREADY is high exactly in ST_ACCEPT and ST_DROP and is decoded
// from the state register alone.
//------------------------------------------------------------------------------
module axis_bram_pingpong_writer
   import axis_bram_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int C_BANK_DEPTH         = 1024,
   parameter int C_BRAM_ADDR_WIDTH    = clog2(C_BANK_DEPTH) + 1
) (
   input  logic                              S_AXIS_ACLK,
   input  logic                              S_AXIS_ARESET,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                              S_AXIS_TLAST,
   output logic                              BRAM_EN,
   output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] BRAM_WE,
   output logic [C_BRAM_ADDR_WIDTH-1:0]      BRAM_ADDR,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]   BRAM_DIN,
   output logic                              FRAME_DONE,
   output logic                              FRAME_BANK,
   output logic [clog2(C_BANK_DEPTH):0]      FRAME_LEN,
   output logic                              FRAME_TRUNC,
   output logic [NUM_BANKS-1:0]              BANK_FULL,
   input  logic [NUM_BANKS-1:0]              BANK_RELEASE
);

   localparam int DW     = C_S_AXIS_TDATA_WIDTH;
   localparam int SW     = C_S_AXIS_TDATA_WIDTH / 8;
   localparam int OFF_W  = clog2(C_BANK_DEPTH);
   localparam int LEN_W  = OFF_W + 1;
   localparam int AW     = C_BRAM_ADDR_WIDTH;

   localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(C_BANK_DEPTH - 1);
   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(C_BANK_DEPTH);

   // FSM and offset counter
   wr_state_e        state_q;
   wr_state_e        state_d;
   logic [OFF_W-1:0] offset_q;
   logic [OFF_W-1:0] offset_d;

   // Registered BRAM port and frame report
   logic             bram_en_q;
   logic             bram_en_d;
   logic [SW-1:0]    bram_we_q;
   logic [SW-1:0]    bram_we_d;
   logic [AW-1:0]    bram_addr_q;
   logic [AW-1:0]    bram_addr_d;
   logic [DW-1:0]    bram_din_q;
   logic [DW-1:0]    bram_din_d;
   logic             done_q;
   logic             done_d;
   logic             done_bank_q;
   logic             done_bank_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_d;
   logic             trunc_q;
   logic             trunc_d;

   // Combinational control
   logic             tready;
   logic             beat_hs;
   logic             write_beat;
   logic             commit;
   logic             wr_bank;
   logic             wr_bank_full;
   logic [SW-1:0]    beat_we;

   //---------------------------------------------------------------------------
   // Bank bookkeeping
   //---------------------------------------------------------------------------
   axis_bram_bank_ctrl u_bank_ctrl (
      .clk_i          (S_AXIS_ACLK),
      .rst_i          (S_AXIS_ARESET),
      .commit_i       (commit),
      .release_i      (BANK_RELEASE),
      .wr_bank_o      (wr_bank),
      .bank_full_o    (BANK_FULL),
      .wr_bank_full_o (wr_bank_full)
   );

   //---------------------------------------------------------------------------
   // Byte enables for a written beat
   //---------------------------------------------------------------------------
`ifdef AXIS_BRAM_TSTRB_EN
   assign beat_we = S_AXIS_TSTRB;
`else
   logic unused_tstrb;
   assign beat_we      = '1;
   assign unused_tstrb = ^S_AXIS_TSTRB;
`endif

   assign tready  = (state_q == ST_ACCEPT) || (state_q == ST_DROP);
   assign beat_hs = S_AXIS_TVALID && tready;

   //---------------------------------------------------------------------------
   // Write FSM: next state, offset, commit decode
   //---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      offset_d   = offset_q;
      write_beat = 1'b0;
      commit     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // One bubble after every commit; also the wait point for a
            // release when the next bank in order is still full.
            if (!wr_bank_full) begin
               state_d = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (beat_hs) begin
               write_beat = 1'b1;
               if (S_AXIS_TLAST) begin
                  commit   = 1'b1;
                  state_d  = ST_IDLE;
                  offset_d = '0;
               end else if (offset_q == LAST_OFF) begin
                  // Bank is now full but the frame continues: keep the
                  // stream flowing and discard the remainder.
                  state_d  = ST_DROP;
                  offset_d = '0;
               end else begin
                  offset_d = offset_q + OFF_W'(1);
               end
            end
         end
         ST_DROP: begin
            if (beat_hs && S_AXIS_TLAST) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            offset_d = '0;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Registered BRAM port and frame report. Address/data are zeroed on idle
   // cycles so the port is quiet whenever no beat is written.
   //---------------------------------------------------------------------------
   always_comb begin
      bram_en_d   = write_beat;
      bram_we_d   = write_beat ? beat_we : '0;
      bram_addr_d = write_beat ? AW'({wr_bank, offset_q}) : '0;
      bram_din_d  = write_beat ? S_AXIS_TDATA : '0;
      done_d      = commit;
      done_bank_d = commit ? wr_bank : 1'b0;
      trunc_d     = commit && (state_q == ST_DROP);
      len_d       = '0;
      if (commit) begin
         // In ACCEPT the TLAST beat itself sits at offset_q, hence +1.
         len_d = (state_q == ST_DROP) ? FULL_LEN : ({1'b0, offset_q} + LEN_W'(1));
      end
   end

   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         state_q     <= ST_IDLE;
         offset_q    <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= '0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         done_q      <= 1'b0;
         done_bank_q <= 1'b0;
         len_q       <= '0;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         done_q      <= done_d;
         done_bank_q <= done_bank_d;
         len_q       <= len_d;
         trunc_q     <= trunc_d;
      end
   end

   assign S_AXIS_TREADY = tready;
   assign BRAM_EN       = bram_en_q;
   assign BRAM_WE       = bram_we_q;
   assign BRAM_ADDR     = bram_addr_q;
   assign BRAM_DIN      = bram_din_q;
   assign FRAME_DONE    = done_q;
   assign FRAME_BANK    = done_bank_q;
   assign FRAME_LEN     = len_q;
   assign FRAME_TRUNC   = trunc_q;

endmodule : axis_bram_pingpong_writer
